head_fifo_burst_sched: RTL

//  Drain scheduler for the command/data head FIFO. Watches the FIFO fill count and

---
 rtl/head_fifo_pkg.sv | 13 +
 rtl/head_fifo_hyst.sv | 38 +++
 rtl/head_fifo_burst_sched.sv | 108 ++++++++++
 3 files changed

// File: rtl/head_fifo_pkg.sv
// Shared types and default thresholds for the head-FIFO drain scheduler.
package head_fifo_pkg;

    typedef enum logic [1:0] {IDLE, REQ, BURST, GAP} state_e;

    localparam int DEF_CNT_W     = 8;
    localparam int DEF_BURST_LEN = 16;
    localparam int DEF_FULL_HI   = 120;
    localparam int DEF_FULL_LO   = 100;
    localparam int DEF_FLUSH_TO  = 255;
    localparam int DEF_GAP_CYC   = 2;

endpackage

// File: rtl/head_fifo_hyst.sv
// Registered FIFO count and upstream backpressure with hysteresis.
module head_fifo_hyst
    import head_fifo_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int FULL_HI = DEF_FULL_HI,
    parameter int FULL_LO = DEF_FULL_LO
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [CNT_W-1:0] i_fifo_num,
    output logic [CNT_W-1:0] o_num_q,
    output logic             o_up_stall
);

    localparam logic [CNT_W-1:0] L_HI = CNT_W'(FULL_HI);
    localparam logic [CNT_W-1:0] L_LO = CNT_W'(FULL_LO);

    logic [CNT_W-1:0] r_num_q;
    logic             r_stall;
    logic             w_stall;

    // Stall reacts in the same cycle the registered count crosses a threshold.
    assign w_stall    = (r_num_q > L_HI) | (r_stall & ~(r_num_q < L_LO));
    assign o_up_stall = w_stall;
    assign o_num_q    = r_num_q;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_num_q <= '0;
            r_stall <= 1'b0;
        end else begin
            r_num_q <= i_fifo_num;
            r_stall <= w_stall;
        end
    end

endmodule

// File: rtl/head_fifo_burst_sched.sv
// Drain scheduler: issues fixed or partial read bursts from the head FIFO downstream.
module head_fifo_burst_sched
    import head_fifo_pkg::*;
#(
    parameter int CNT_W     = DEF_CNT_W,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int FULL_HI   = DEF_FULL_HI,
    parameter int FULL_LO   = DEF_FULL_LO,
    parameter int FLUSH_TO  = DEF_FLUSH_TO,
    parameter int GAP_CYC   = DEF_GAP_CYC
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [CNT_W-1:0] i_fifo_num,
    input  logic             i_fifo_empty,
    input  logic             i_flush_req,
    input  logic             i_dn_grant,
    input  logic             i_dn_ready,
    output logic             o_fifo_rd_en,
    output logic             o_dn_req,
    output logic             o_dn_last,
    output logic [CNT_W-1:0] o_burst_len,
    output logic             o_up_stall,
    output logic             o_busy
);

    localparam logic [CNT_W-1:0] L_BURST = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] L_TO    = CNT_W'(FLUSH_TO);
    localparam logic [CNT_W-1:0] L_GAPM1 = CNT_W'(GAP_CYC - 1);

    state_e           r_state, w_nxt;
    logic [CNT_W-1:0] r_timer, r_len, r_beat, r_gap;
    logic [CNT_W-1:0] w_num_q;
    logic             w_rd, w_last, w_start;

    head_fifo_hyst #(
        .CNT_W   (CNT_W),
        .FULL_HI (FULL_HI),
        .FULL_LO (FULL_LO)
    ) u_hyst (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_fifo_num (i_fifo_num),
        .o_num_q    (w_num_q),
        .o_up_stall (o_up_stall)
    );

    always_comb begin
        w_nxt       = r_state;
        w_rd        = 1'b0;
        w_last      = 1'b0;
        o_dn_req    = 1'b0;
        o_burst_len = '0;
        case (r_state)
            IDLE: begin
                // Full burst is checked first so it wins over a concurrent flush.
                if (w_num_q >= L_BURST)
                    w_nxt = REQ;
                else if ((w_num_q != '0) && ((r_timer == L_TO) || i_flush_req))
                    w_nxt = REQ;
            end
            REQ: begin
                o_dn_req    = 1'b1;
                o_burst_len = r_len;
                if (i_dn_grant) w_nxt = BURST;
            end
            BURST: begin
                o_burst_len = r_len;
                w_rd        = i_dn_ready & ~i_fifo_empty;
                w_last      = w_rd & (r_beat == r_len - 1'b1);
                if (w_last) w_nxt = GAP;
            end
            GAP: begin
                if (r_gap == L_GAPM1) w_nxt = IDLE;
            end
            default: w_nxt = IDLE;
        endcase
    end

    assign w_start      = (r_state == IDLE) && (w_nxt == REQ);
    assign o_fifo_rd_en = w_rd;
    assign o_dn_last    = w_last;
    assign o_busy       = (r_state != IDLE);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_gap   <= '0;
        end else begin
            r_state <= w_nxt;
            if ((r_state == IDLE) && (w_num_q != '0) && (w_num_q < L_BURST))
                r_timer <= (r_timer == L_TO) ? r_timer : r_timer + 1'b1;
            else
                r_timer <= '0;
            if (w_start) begin
                r_len  <= (w_num_q >= L_BURST) ? L_BURST : w_num_q;
                r_beat <= '0;
            end else if (w_rd) begin
                r_beat <= r_beat + 1'b1;
            end
            r_gap <= (r_state == GAP) ? r_gap + 1'b1 : '0;
        end
    end

endmodule
